// File: rtl/seg7_capture.sv
`default_nettype none
// =============================================================================
// Module   : seg7_capture
// Purpose  : Samples NDIGITS 7-segment buses, debounces each digit over
//            STABLE_CYCLES samples and recovers the displayed hex nibble.
//            Optional illegal-commit counter: define SEG7_CAPTURE_ERRCNT_EN.
// Revision : 1.0 - initial release
// =============================================================================
module seg7_capture #(
    parameter int NDIGITS       = 6,
    parameter int STABLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7*NDIGITS-1:0]   seg,
`ifdef SEG7_CAPTURE_ERRCNT_EN
    input  logic                   err_clr,
    output logic [15:0]            err_count,
`endif
    output logic [4*NDIGITS-1:0]   value,
    output logic [NDIGITS-1:0]     valid_mask,
    output logic [NDIGITS-1:0]     blank_mask,
    output logic                   update,
    output logic                   err
);

    localparam int                 c_CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_PRE = c_CNT_W'(STABLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    // Returns {legal, nibble} for an active-low pattern (bit 6 = g ... bit 0 = a).
    function automatic logic [4:0] f_decode(input logic [6:0] pat);
        case (pat)
            7'b1000000: f_decode = {1'b1, 4'h0};
            7'b1111001: f_decode = {1'b1, 4'h1};
            7'b0100100: f_decode = {1'b1, 4'h2};
            7'b0110000: f_decode = {1'b1, 4'h3};
            7'b0011001: f_decode = {1'b1, 4'h4};
            7'b0010010: f_decode = {1'b1, 4'h5};
            7'b0000010: f_decode = {1'b1, 4'h6};
            7'b1111000: f_decode = {1'b1, 4'h7};
            7'b0000000: f_decode = {1'b1, 4'h8};
            7'b0010000: f_decode = {1'b1, 4'h9};
            7'b0001000: f_decode = {1'b1, 4'hA};
            7'b0000011: f_decode = {1'b1, 4'hB};
            7'b1000110: f_decode = {1'b1, 4'hC};
            7'b0100001: f_decode = {1'b1, 4'hD};
            7'b0000110: f_decode = {1'b1, 4'hE};
            7'b0001110: f_decode = {1'b1, 4'hF};
            default:    f_decode = 5'b0_0000;
        endcase
    endfunction

    logic [7*NDIGITS-1:0] w_seg_norm;
    logic [7*NDIGITS-1:0] r_seg_q;
    logic [NDIGITS-1:0]   w_commit;
    logic [NDIGITS-1:0]   w_illegal;
    logic [NDIGITS-1:0]   w_changed;
    logic                 r_update;
    logic                 r_err;

    assign w_seg_norm = (ACTIVE_LOW != 0) ? seg : ~seg;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seg_q <= '1;
        end else begin
            r_seg_q <= w_seg_norm;
        end
    end

    generate
        for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
            logic [6:0]         w_pat;
            logic [4:0]         w_dec;
            logic               w_is_blank;
            logic [3:0]         w_new_value;
            logic [6:0]         r_last;
            logic [c_CNT_W-1:0] r_cnt;
            logic [3:0]         r_value;
            logic               r_valid;
            logic               r_blank;

            assign w_pat       = r_seg_q[7*gi +: 7];
            assign w_dec       = f_decode(w_pat);
            assign w_is_blank  = (w_pat == 7'h7F);
            assign w_new_value = w_dec[4] ? w_dec[3:0] : r_value;

            // Commit exactly on the S-1 -> S step; a saturated run never re-commits.
            assign w_commit[gi]  = (w_pat == r_last) && (r_cnt == c_CNT_PRE);
            assign w_illegal[gi] = w_commit[gi] && !w_dec[4] && !w_is_blank;
            assign w_changed[gi] = w_commit[gi] &&
                ({w_dec[4], w_is_blank, w_new_value} != {r_valid, r_blank, r_value});

            always_ff @(posedge clk) begin
                if (reset) begin
                    r_last  <= 7'h7F;
                    r_cnt   <= '0;
                    r_value <= 4'h0;
                    r_valid <= 1'b0;
                    r_blank <= 1'b0;
                end else begin
                    if (w_pat != r_last) begin
                        r_last <= w_pat;
                        r_cnt  <= '0;
                    end else if (r_cnt < c_CNT_MAX) begin
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                    if (w_commit[gi]) begin
                        r_value <= w_new_value;
                        r_valid <= w_dec[4];
                        r_blank <= w_is_blank;
                    end
                end
            end

            assign value[4*gi +: 4] = r_value;
            assign valid_mask[gi]   = r_valid;
            assign blank_mask[gi]   = r_blank;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_update <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_update <= |w_changed;
            r_err    <= |w_illegal;
        end
    end

    assign update = r_update;
    assign err    = r_err;

`ifdef SEG7_CAPTURE_ERRCNT_EN
    logic [3:0]  w_ill_cnt;
    logic [16:0] w_sum;
    logic [15:0] r_err_count;

    always_comb begin
        w_ill_cnt = 4'd0;
        for (int j = 0; j < NDIGITS; j++) begin
            w_ill_cnt = w_ill_cnt + {3'b000, w_illegal[j]};
        end
    end

    assign w_sum = {1'b0, r_err_count} + {13'd0, w_ill_cnt};

    always_ff @(posedge clk) begin
        if (reset || err_clr) begin
            r_err_count <= 16'h0000;
        end else if (w_sum[16]) begin
            r_err_count <= 16'hFFFF;
        end else begin
            r_err_count <= w_sum[15:0];
        end
    end

    assign err_count = r_err_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_seg7_capture.sv
`default_nettype none
// =============================================================================
// Module   : tb_seg7_capture
// Purpose  : Self-checking bench for seg7_capture (table vectors + scoreboard).
// Revision : 1.0 - initial release
// =============================================================================
module tb_seg7_capture;

    localparam int NDIGITS       = 6;
    localparam int STABLE_CYCLES = 4;
    localparam int LAT           = STABLE_CYCLES + 2;   // drive-to-visible edges

    localparam logic [6:0] G0   = 7'b1000000;
    localparam logic [6:0] G1   = 7'b1111001;
    localparam logic [6:0] G3   = 7'b0110000;
    localparam logic [6:0] G7   = 7'b1111000;
    localparam logic [6:0] G8   = 7'b0000000;
    localparam logic [6:0] GA   = 7'b0001000;
    localparam logic [6:0] GF   = 7'b0001110;
    localparam logic [6:0] BL   = 7'b1111111;
    localparam logic [6:0] ILL1 = 7'b1010101;
    localparam logic [6:0] ILL2 = 7'b0101010;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [7*NDIGITS-1:0] seg;
    logic [4*NDIGITS-1:0] value;
    logic [NDIGITS-1:0]   valid_mask;
    logic [NDIGITS-1:0]   blank_mask;
    logic                 update;
    logic                 err;
`ifdef SEG7_CAPTURE_ERRCNT_EN
    logic                 err_clr;
    logic [15:0]          err_count;
`endif

    seg7_capture #(
        .NDIGITS       (NDIGITS),
        .STABLE_CYCLES (STABLE_CYCLES),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg        (seg),
`ifdef SEG7_CAPTURE_ERRCNT_EN
        .err_clr    (err_clr),
        .err_count  (err_count),
`endif
        .value      (value),
        .valid_mask (valid_mask),
        .blank_mask (blank_mask),
        .update     (update),
        .err        (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [41:0] seg;
        logic [23:0] value;
        logic [5:0]  valid;
        logic [5:0]  blank;
        logic        upd;
        logic        err;
        string       name;
    } vec_t;

    typedef struct {
        int          cyc;
        logic [23:0] value;
        logic [5:0]  valid;
        logic [5:0]  blank;
        logic        upd;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [41:0] pack6(input logic [6:0] d5, input logic [6:0] d4,
                                          input logic [6:0] d3, input logic [6:0] d2,
                                          input logic [6:0] d1, input logic [6:0] d0);
        return {d5, d4, d3, d2, d1, d0};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_out(input string nm, input logic [23:0] v,
                             input logic [5:0] va, input logic [5:0] bl);
        n_checks++;
        if (value !== v || valid_mask !== va || blank_mask !== bl) begin
            n_errors++;
            $display("FAIL %s: got value=%h valid=%b blank=%b, expected value=%h valid=%b blank=%b",
                     nm, value, valid_mask, blank_mask, v, va, bl);
        end
    endtask

    task automatic push_exp(input int c, input logic [23:0] v, input logic [5:0] va,
                            input logic [5:0] bl, input logic u, input logic e);
        exp_t x;
        x.cyc = c; x.value = v; x.valid = va; x.blank = bl; x.upd = u; x.err = e;
        sb.push_back(x);
    endtask

    // Pulse monitor: every update/err pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            n_checks++;
            n_errors++;
            $display("FAIL missed_pulse: got no pulse at edge %0d, expected update=%b err=%b",
                     sb[0].cyc, sb[0].upd, sb[0].err);
            void'(sb.pop_front());
        end
        if (update === 1'b1 || err === 1'b1) begin
            n_checks++;
            if (sb.size() == 0 || sb[0].cyc != cyc) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got update=%b err=%b at edge %0d, expected none",
                         update, err, cyc);
            end else begin
                e = sb.pop_front();
                if (update !== e.upd || err !== e.err || value !== e.value ||
                    valid_mask !== e.valid || blank_mask !== e.blank) begin
                    n_errors++;
                    $display("FAIL pulse_edge_%0d: got upd=%b err=%b value=%h valid=%b blank=%b, expected upd=%b err=%b value=%h valid=%b blank=%b",
                             cyc, update, err, value, valid_mask, blank_mask,
                             e.upd, e.err, e.value, e.valid, e.blank);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    vec_t        vecs[9];
    logic [23:0] p_value;
    logic [5:0]  p_valid;
    logic [5:0]  p_blank;
    int          n0;
    int          r;

    initial begin
        vecs[0] = '{pack6(BL, BL, BL, BL, GA, G0), 24'h0000A0, 6'h03, 6'h3C, 1'b1, 1'b0, "v_d0_0_d1_A"};
        vecs[1] = '{pack6(BL, BL, G3, BL, GA, G0), 24'h0030A0, 6'h0B, 6'h34, 1'b1, 1'b0, "v_d3_3"};
        vecs[2] = '{pack6(BL, BL, ILL1, BL, GA, G0), 24'h0030A0, 6'h03, 6'h34, 1'b1, 1'b1, "v_d3_illegal"};
        vecs[3] = '{pack6(G7, G7, G7, G7, G7, G7), 24'h777777, 6'h3F, 6'h00, 1'b1, 1'b0, "v_all_7"};
        vecs[4] = '{pack6(G8, G8, G8, G8, G8, G8), 24'h888888, 6'h3F, 6'h00, 1'b1, 1'b0, "v_all_8"};
        vecs[5] = '{pack6(GF, G8, G8, G8, G8, G8), 24'hF88888, 6'h3F, 6'h00, 1'b1, 1'b0, "v_d5_F"};
        vecs[6] = '{pack6(GF, ILL1, G8, G8, G8, G8), 24'hF88888, 6'h2F, 6'h00, 1'b1, 1'b1, "v_d4_illegal"};
        vecs[7] = '{pack6(GF, ILL2, G8, G8, G8, G8), 24'hF88888, 6'h2F, 6'h00, 1'b0, 1'b1, "v_d4_illegal_again"};
        vecs[8] = '{pack6(BL, BL, BL, BL, BL, BL), 24'hF88888, 6'h00, 6'h3F, 1'b1, 1'b0, "v_all_blank"};

        reset = 1'b1;
        seg   = pack6(BL, BL, BL, BL, BL, BL);
`ifdef SEG7_CAPTURE_ERRCNT_EN
        err_clr = 1'b0;
`endif
        tick(3);
        check_out("reset_state", 24'h0, 6'h00, 6'h00);
        n_checks++;
        if (update !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_pulses: got update=%b err=%b, expected 0 0", update, err);
        end

        // Blank display through reset: commits blank STABLE_CYCLES edges after release.
        reset = 1'b0;
        r = cyc;
        push_exp(r + STABLE_CYCLES, 24'h0, 6'h00, 6'h3F, 1'b1, 1'b0);
        tick(STABLE_CYCLES - 1);
        check_out("blank_pre_commit", 24'h0, 6'h00, 6'h00);
        tick(1);
        check_out("blank_commit", 24'h0, 6'h00, 6'h3F);
        tick(3);

        p_value = 24'h0; p_valid = 6'h00; p_blank = 6'h3F;
        for (int i = 0; i < 9; i++) begin
            seg = vecs[i].seg;
            n0  = cyc;
            if (vecs[i].upd || vecs[i].err)
                push_exp(n0 + LAT, vecs[i].value, vecs[i].valid, vecs[i].blank,
                         vecs[i].upd, vecs[i].err);
            tick(LAT - 1);
            check_out({vecs[i].name, "_hold"}, p_value, p_valid, p_blank);
            tick(1);
            check_out({vecs[i].name, "_commit"}, vecs[i].value, vecs[i].valid, vecs[i].blank);
            tick(3);
            check_out({vecs[i].name, "_steady"}, vecs[i].value, vecs[i].valid, vecs[i].blank);
`ifdef SEG7_CAPTURE_ERRCNT_EN
            if (i == 7) begin
                n_checks++;
                if (err_count !== 16'd3) begin
                    n_errors++;
                    $display("FAIL err_count_accum: got %0d, expected 3", err_count);
                end
            end
`endif
            p_value = vecs[i].value; p_valid = vecs[i].valid; p_blank = vecs[i].blank;
        end

        // Digit 2 toggles every 3 samples: never stable long enough to commit.
        for (int t = 0; t < 8; t++) begin
            seg = pack6(BL, BL, BL, (t % 2 == 0) ? G3 : G1, BL, BL);
            tick(3);
        end
        seg = pack6(BL, BL, BL, BL, BL, BL);
        tick(12);
        check_out("toggle_no_commit", 24'hF88888, 6'h00, 6'h3F);

        // All digits to 8, then a 2-cycle glitch to 7 and back: one update only.
        seg = pack6(G8, G8, G8, G8, G8, G8);
        n0  = cyc;
        push_exp(n0 + LAT, 24'h888888, 6'h3F, 6'h00, 1'b1, 1'b0);
        tick(LAT + 2);
        check_out("all8_commit", 24'h888888, 6'h3F, 6'h00);
        seg = pack6(G7, G7, G7, G7, G7, G7);
        tick(2);
        seg = pack6(G8, G8, G8, G8, G8, G8);
        tick(3);
        check_out("glitch_hold", 24'h888888, 6'h3F, 6'h00);
        tick(10);
        check_out("glitch_recommit", 24'h888888, 6'h3F, 6'h00);

        // Reset three cycles into a stable run of zeros.
        seg = pack6(G0, G0, G0, G0, G0, G0);
        tick(3);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        r = cyc;
        check_out("midreset_zero", 24'h0, 6'h00, 6'h00);
        n_checks++;
        if (update !== 1'b0 || err !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_pulses: got update=%b err=%b, expected 0 0", update, err);
        end
        push_exp(r + STABLE_CYCLES + 2, 24'h0, 6'h3F, 6'h00, 1'b1, 1'b0);
        tick(STABLE_CYCLES + 1);
        check_out("midreset_hold", 24'h0, 6'h00, 6'h00);
        tick(1);
        check_out("midreset_commit", 24'h0, 6'h3F, 6'h00);
        tick(3);

`ifdef SEG7_CAPTURE_ERRCNT_EN
        n_checks++;
        if (err_count !== 16'd0) begin
            n_errors++;
            $display("FAIL err_count_reset: got %0d, expected 0", err_count);
        end
        // err_clr coinciding with an illegal commit wins.
        seg = pack6(G0, G0, G0, G0, G0, ILL1);
        n0  = cyc;
        push_exp(n0 + LAT, 24'h0, 6'h3E, 6'h00, 1'b1, 1'b1);
        tick(LAT - 1);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        n_checks++;
        if (err_count !== 16'd0) begin
            n_errors++;
            $display("FAIL err_clr_priority: got %0d, expected 0", err_count);
        end
        tick(3);
`endif

        tick(2);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drained: got %0d pending, expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
